// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic [0:0] {StIdle, StGrant} arb_state_t;

    // Index width that stays at least one bit wide when there is a single requester.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned NUM_REQ   = 4;
    localparam int unsigned BURST_LEN = 4;
    localparam int unsigned ID_W      = id_width(NUM_REQ);
    localparam int unsigned BURST_W   = $clog2(BURST_LEN + 1);

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority picker: first asserted request at or after start_i, wrapping modulo NumReq.
module rr_priority_pick #(
    parameter int unsigned NumReq = 4,
    parameter int unsigned IdW    = 2
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdW-1:0]    start_i,
    output logic              found_o,
    output logic [IdW-1:0]    idx_o
);

    always_comb begin
        int unsigned k;
        found_o = 1'b0;
        idx_o   = '0;
        k       = 0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            k = (32'(start_i) + i) % NumReq;
            if (!found_o && req_i[k]) begin
                found_o = 1'b1;
                idx_o   = IdW'(k);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among valid/ready producers,
// holding each grant for bursts of up to BURST_LEN beats and stalling on full.
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned Data_Width = 8,
    parameter int unsigned BURST_LEN  = 4,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned ID_W       = fifo_arb_pkg::id_width(NUM_REQ)
) (
    input  logic                             wr_clk,
    input  logic                             wr_rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*Data_Width-1:0]    req_data,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic                             full,
    output logic                             wr_en,
    output logic [Data_Width-1:0]            data_in,
    output logic                             grant_active,
    output logic [ID_W-1:0]                  grant_id,
    output logic [CNT_W-1:0]                 total_writes
);

    import fifo_arb_pkg::*;

    localparam int unsigned BurstW = $clog2(BURST_LEN + 1);

    arb_state_t        state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic [BurstW-1:0] beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]  total_q, total_d;

    logic              pick_found;
    logic [ID_W-1:0]   pick_idx;
    logic              cur_valid;
    logic              last_beat;
    logic [ID_W-1:0]   next_ptr;

    rr_priority_pick #(
        .NumReq (NUM_REQ),
        .IdW    (ID_W)
    ) u_pick (
        .req_i   (req_valid),
        .start_i (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    assign cur_valid = req_valid[grant_id_q];
    assign last_beat = (beat_cnt_q == BurstW'(BURST_LEN - 1));
    assign next_ptr  = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

    // Handshake outputs; gated by reset so an abandoned burst never writes.
    always_comb begin
        req_ready = '0;
        wr_en     = 1'b0;
        data_in   = req_data[32'(grant_id_q) * Data_Width +: Data_Width];
        if (state_q == StGrant && !wr_rst) begin
            req_ready[grant_id_q] = !full;
            wr_en                 = cur_valid & !full;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        beat_cnt_d = beat_cnt_q;
        total_d    = total_q;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    grant_id_d = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = StGrant;
                end
            end
            StGrant: begin
                if (wr_en) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    total_d    = total_q + 1'b1;
                end
                // full freezes the burst but never ends it; only a dropped valid or the last beat does.
                if ((wr_en && last_beat) || !cur_valid) begin
                    state_d    = StIdle;
                    rr_ptr_d   = next_ptr;
                    beat_cnt_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            beat_cnt_q <= '0;
            total_q    <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            beat_cnt_q <= beat_cnt_d;
            total_q    <= total_d;
        end
    end

    assign grant_active = (state_q == StGrant);
    assign grant_id     = grant_id_q;
    assign total_writes = total_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: expected writes queued with stimulus, checked at wr_en.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int BL = 4;
    localparam int CW = 4;

    logic              wr_clk = 1'b0;
    logic              wr_rst;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              full;
    logic              wr_en;
    logic [DW-1:0]     data_in;
    logic              grant_active;
    logic [1:0]        grant_id;
    logic [CW-1:0]     total_writes;

    fifo_wr_arbiter #(
        .NUM_REQ    (NR),
        .Data_Width (DW),
        .BURST_LEN  (BL),
        .CNT_W      (CW)
    ) dut (
        .wr_clk       (wr_clk),
        .wr_rst       (wr_rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .full         (full),
        .wr_en        (wr_en),
        .data_in      (data_in),
        .grant_active (grant_active),
        .grant_id     (grant_id),
        .total_writes (total_writes)
    );

    always #5 wr_clk = ~wr_clk;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    exp_t          exp_q[$];
    logic [7:0]    src[NR][$];
    bit            en[NR];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc = 0;
    int            wr_cyc[$];
    logic [CW-1:0] exp_total = '0;
    logic          last_wr, last_act;
    logic [NR-1:0] last_ready;
    logic [1:0]    last_gid;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic push(input int id, input int d);
        exp_t e;
        e.id   = 2'(id);
        e.data = 8'(d);
        exp_q.push_back(e);
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req_valid[i]         = en[i] && (src[i].size() > 0);
            req_data[i*DW +: DW] = (src[i].size() > 0) ? src[i][0] : 8'h00;
        end
    endtask

    // One cycle: sample on the falling edge, then advance past the rising edge and redrive.
    task automatic tick();
        logic [NR-1:0] xfer;
        logic          rst_now;
        exp_t          e;
        #4;
        xfer       = req_valid & req_ready;
        rst_now    = wr_rst;
        last_wr    = wr_en;
        last_act   = grant_active;
        last_ready = req_ready;
        last_gid   = grant_id;
        if (!rst_now) check("total_writes", total_writes, exp_total);
        check("accept_vs_wr_en", |xfer, wr_en);
        if (wr_en) begin
            check("wr_while_full", full, 1'b0);
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("wr_data", data_in, e.data);
                check("wr_id", grant_id, e.id);
                check("ready_onehot", req_ready, 4'(1) << e.id);
            end
            wr_cyc.push_back(cyc);
            exp_total++;
        end
        @(posedge wr_clk);
        #1;
        if (rst_now) exp_total = '0;
        for (int i = 0; i < NR; i++) if (xfer[i]) void'(src[i].pop_front());
        cyc++;
        drive();
    endtask

    task automatic wait_writes(input string tag, input int n);
        for (int k = 0; k < 60 && wr_cyc.size() < n; k++) tick();
        check(tag, wr_cyc.size(), n);
    endtask

    task automatic wait_drain(input string tag);
        for (int k = 0; k < 300 && exp_q.size() > 0; k++) tick();
        check(tag, exp_q.size(), 0);
        repeat (3) tick();
    endtask

    task automatic do_reset();
        wr_rst = 1'b1;
        tick();
        tick();
        wr_rst = 1'b0;
        drive();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_act"}, grant_active, 1'b0);
        check({tag, "_gid"}, grant_id, 2'd0);
        check({tag, "_total"}, total_writes, '0);
        check({tag, "_wr_en"}, wr_en, 1'b0);
        check({tag, "_ready"}, req_ready, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        wr_rst    = 1'b1;
        full      = 1'b0;
        req_valid = '0;
        req_data  = '0;
        for (int i = 0; i < NR; i++) en[i] = 1'b0;
        do_reset();
        check_reset_vals("reset");

        // Single requester, 6 words: 4-beat burst, bubble, 2 beats.
        en[0] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            src[0].push_back(8'(8'h10 + k));
            push(0, 8'h10 + k);
        end
        wr_cyc.delete();
        drive();
        wait_drain("t1_drain");
        check("t1_burst_span", wr_cyc[3] - wr_cyc[0], 3);
        check("t1_bubble", wr_cyc[4] - wr_cyc[3], 2);
        check("t1_tail", wr_cyc[5] - wr_cyc[4], 1);
        check("t1_total", total_writes, 6);

        // rr_ptr should now be 1: requester 1 beats requester 0.
        en[1] = 1'b1;
        src[0].push_back(8'hA0);
        src[1].push_back(8'hB0);
        push(1, 8'hB0);
        push(0, 8'hA0);
        drive();
        wait_drain("t1_rr_drain");
        en[0] = 1'b0;
        en[1] = 1'b0;

        // All four continuously valid: grants 0,1,2,3,0,1,2,3.
        do_reset();
        for (int i = 0; i < NR; i++) begin
            en[i] = 1'b1;
            for (int k = 0; k < 8; k++) src[i].push_back(8'(i * 16 + k));
        end
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NR; i++)
                for (int k = 0; k < BL; k++) push(i, i * 16 + r * 4 + k);
        wr_cyc.delete();
        drive();
        wait_drain("t2_drain");
        check("t2_span", wr_cyc[31] - wr_cyc[0], 38);
        check("t2_bubble", wr_cyc[4] - wr_cyc[3], 2);
        for (int i = 0; i < NR; i++) en[i] = 1'b0;

        // Requester 2 stalled by full for 5 cycles after its first beat.
        en[2] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            src[2].push_back(8'(8'h20 + k));
            push(2, 8'h20 + k);
        end
        wr_cyc.delete();
        drive();
        wait_writes("t3_first", 1);
        full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t3_stall_wr", last_wr, 1'b0);
            check("t3_stall_ready", last_ready[2], 1'b0);
            check("t3_stall_gid", last_gid, 2'd2);
            check("t3_stall_act", last_act, 1'b1);
        end
        full = 1'b0;
        wait_writes("t3_burst", 4);
        tick();
        check("t3_exit", last_act, 1'b0);
        wait_drain("t3_drain");
        check("t3_stall_gap", wr_cyc[1] - wr_cyc[0], 6);
        en[2] = 1'b0;

        // Requester 1 drops valid after 2 beats; next search starts at 2.
        en[1] = 1'b1;
        for (int k = 0; k < 4; k++) src[1].push_back(8'(8'h30 + k));
        push(1, 8'h30);
        push(1, 8'h31);
        wr_cyc.delete();
        drive();
        wait_writes("t4_two", 2);
        en[1] = 1'b0;
        en[0] = 1'b1;
        en[2] = 1'b1;
        src[0].push_back(8'h50);
        src[2].push_back(8'h40);
        push(2, 8'h40);
        push(0, 8'h50);
        drive();
        tick();
        check("t4_hold_act", last_act, 1'b1);
        check("t4_hold_wr", last_wr, 1'b0);
        tick();
        check("t4_exit", last_act, 1'b0);
        wait_drain("t4_drain");
        check("t4_leftover", src[1].size(), 2);
        src[1].delete();
        en[0] = 1'b0;
        en[2] = 1'b0;

        // Reset mid-burst on requester 3 while requester 0 also waits.
        en[0] = 1'b1;
        en[3] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            src[0].push_back(8'(8'h70 + k));
            src[3].push_back(8'(8'h60 + k));
        end
        push(3, 8'h60);
        push(3, 8'h61);
        wr_cyc.delete();
        drive();
        wait_writes("t5_two", 2);
        wr_rst = 1'b1;
        drive();
        tick();
        check("t5_rst_wr", last_wr, 1'b0);
        check("t5_rst_ready", last_ready, '0);
        wr_rst = 1'b0;
        drive();
        check_reset_vals("t5_after");
        for (int k = 0; k < 4; k++) push(0, 8'h70 + k);
        push(3, 8'h62);
        push(3, 8'h63);
        wait_drain("t5_drain");
        en[0] = 1'b0;
        en[3] = 1'b0;

        // 17 writes wrap the 4-bit counter to 1.
        do_reset();
        en[0] = 1'b1;
        for (int k = 0; k < 17; k++) begin
            src[0].push_back(8'(8'h80 + k));
            push(0, 8'h80 + k);
        end
        drive();
        wait_drain("t6_drain");
        check("t6_wrap", total_writes, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
